// File: rtl/pll_clock_sequencer_pkg.sv
// Shared definitions for the PLL clock sequencer: state encoding,
// parameter defaults and a small sizing helper.
package pll_clock_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    localparam int DEF_RESET_CYCLES  = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65536;
    localparam int DEF_SETTLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 3;

    // Largest of three cycle counts; sizes the shared phase timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/pll_clock_sequencer_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the
// board clock domain. Output lags the input by two clock edges.
module lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next values of the two synchronizer stages.
    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
    end

    // Synchronizer flops, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_clock_sequencer.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for lock, requires
// a settle window of continuous lock, then enables the downstream counter.
// Failed attempts retry up to MAX_RETRIES times before latching a fault.
module pll_clock_sequencer
    import pll_clock_sequencer_pkg::*;
#(
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic       CLK,
    input  logic       RESETB,
    input  logic       LOCK,
    input  logic       RESTART,
    output logic       PLL_RESETB,
    output logic       CNT_EN,
    output logic       CNT_CLR,
    output logic       READY,
    output logic       FAULT,
    output logic [2:0] STATE,
    output logic [7:0] LOSS_CNT
);

    localparam int TW = $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)) + 1;
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    // Terminal counts: the timer starts at zero on phase entry, so the
    // last cycle of an N-cycle phase sees N-1.
    localparam logic [TW-1:0] RESET_LAST   = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

    state_e          state_q;
    state_e          state_d;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_d;
    logic [TW-1:0]   timer_inc_s;
    logic [RW-1:0]   retry_q;
    logic [RW-1:0]   retry_d;
    logic [7:0]      loss_q;
    logic [7:0]      loss_d;
    logic            lock_s;
    logic            fail_s;

    lock_sync u_lock_sync (
        .clk     (CLK),
        .rst_n   (RESETB),
        .async_i (LOCK),
        .sync_o  (lock_s)
    );

    // State register.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q <= ST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Phase timer, retry counter and lock-loss counter registers.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            timer_q <= '0;
            retry_q <= '0;
            loss_q  <= 8'd0;
        end else begin
            timer_q <= timer_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    // Next-state logic; RESTART overrides every other transition.
    always_comb begin
        state_d     = state_q;
        timer_inc_s = timer_q + TW'(1);
        retry_d     = retry_q;
        loss_d      = loss_q;
        fail_s      = 1'b0;
        timer_d     = timer_q;

        if (RESTART) begin
            state_d = ST_HOLD;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (timer_q == RESET_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        timer_d = timer_inc_s;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock takes precedence over a coincident timeout.
                    if (lock_s) begin
                        state_d = ST_SETTLE;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        fail_s = 1'b1;
                    end else begin
                        timer_d = timer_inc_s;
                    end
                end
                ST_SETTLE: begin
                    if (!lock_s) begin
                        fail_s = 1'b1;
                    end else if (timer_q == SETTLE_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        timer_d = timer_inc_s;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_HOLD;
                        retry_d = '0;
                        if (loss_q != 8'hFF) begin
                            loss_d = loss_q + 8'd1;
                        end else begin
                            loss_d = loss_q;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase

            if (fail_s) begin
                if (retry_q == RETRY_MAX) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_HOLD;
                    retry_d = retry_q + RW'(1);
                end
            end else begin
                retry_d = retry_d;
            end
        end

        // Every phase starts counting from zero; RESTART also clears the
        // timer when the FSM is already in HOLD.
        if (RESTART || (state_d != state_q)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_d;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        PLL_RESETB = 1'b0;
        CNT_EN     = 1'b0;
        CNT_CLR    = 1'b1;
        READY      = 1'b0;
        FAULT      = 1'b0;
        case (state_q)
            ST_HOLD: begin
                PLL_RESETB = 1'b0;
            end
            ST_WAIT_LOCK: begin
                PLL_RESETB = 1'b1;
            end
            ST_SETTLE: begin
                PLL_RESETB = 1'b1;
            end
            ST_RUN: begin
                PLL_RESETB = 1'b1;
                CNT_EN     = 1'b1;
                CNT_CLR    = 1'b0;
                READY      = 1'b1;
            end
            ST_FAULT: begin
                FAULT = 1'b1;
            end
            default: begin
                PLL_RESETB = 1'b0;
            end
        endcase
    end

    assign STATE    = state_q;
    assign LOSS_CNT = loss_q;

endmodule

// File: tb/tb_pll_clock_sequencer.sv
// Directed bench for pll_clock_sequencer with small timing parameters.
module tb_pll_clock_sequencer;

    logic       CLK;
    logic       RESETB;
    logic       LOCK;
    logic       RESTART;
    logic       PLL_RESETB;
    logic       CNT_EN;
    logic       CNT_CLR;
    logic       READY;
    logic       FAULT;
    logic [2:0] STATE;
    logic [7:0] LOSS_CNT;

    int cmp_cnt;
    int fail_cnt;

    localparam logic [7:0] S_HOLD   = 8'd0;
    localparam logic [7:0] S_WAIT   = 8'd1;
    localparam logic [7:0] S_SETTLE = 8'd2;
    localparam logic [7:0] S_RUN    = 8'd3;
    localparam logic [7:0] S_FAULT  = 8'd4;

    pll_clock_sequencer #(
        .RESET_CYCLES  (4),
        .LOCK_TIMEOUT  (32),
        .SETTLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .CLK        (CLK),
        .RESETB     (RESETB),
        .LOCK       (LOCK),
        .RESTART    (RESTART),
        .PLL_RESETB (PLL_RESETB),
        .CNT_EN     (CNT_EN),
        .CNT_CLR    (CNT_CLR),
        .READY      (READY),
        .FAULT      (FAULT),
        .STATE      (STATE),
        .LOSS_CNT   (LOSS_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_state(input logic [7:0] want, input int budget, input string tag);
        int n;
        n = 0;
        while ((STATE !== want[2:0]) && (n < budget)) begin
            step(1);
            n++;
        end
        check(tag, {5'd0, STATE}, want);
    endtask

    initial begin
        cmp_cnt  = 0;
        fail_cnt = 0;
        RESETB   = 1'b1;
        LOCK     = 1'b0;
        RESTART  = 1'b0;
        #1 RESETB = 1'b0;
        step(3);

        // Reset values
        check("rst_state",  {5'd0, STATE}, S_HOLD);
        check("rst_pllrb",  {7'd0, PLL_RESETB}, 8'd0);
        check("rst_cnten",  {7'd0, CNT_EN}, 8'd0);
        check("rst_cntclr", {7'd0, CNT_CLR}, 8'd1);
        check("rst_ready",  {7'd0, READY}, 8'd0);
        check("rst_fault",  {7'd0, FAULT}, 8'd0);
        check("rst_loss",   LOSS_CNT, 8'd0);

        // Clean start: HOLD lasts exactly 4 cycles
        RESETB = 1'b1;
        step(3);
        check("hold_3_pllrb", {7'd0, PLL_RESETB}, 8'd0);
        check("hold_3_state", {5'd0, STATE}, S_HOLD);
        step(1);
        check("hold_4_pllrb", {7'd0, PLL_RESETB}, 8'd1);
        check("hold_4_state", {5'd0, STATE}, S_WAIT);
        step(10);
        LOCK = 1'b1;
        step(2);
        check("sync_lag_state", {5'd0, STATE}, S_WAIT);
        step(1);
        check("settle_entry", {5'd0, STATE}, S_SETTLE);
        step(7);
        check("settle_last", {5'd0, STATE}, S_SETTLE);
        check("settle_cnten", {7'd0, CNT_EN}, 8'd0);
        step(1);
        check("run_state", {5'd0, STATE}, S_RUN);
        check("run_cnten", {7'd0, CNT_EN}, 8'd1);
        check("run_ready", {7'd0, READY}, 8'd1);
        check("run_cntclr", {7'd0, CNT_CLR}, 8'd0);

        // Lock loss in RUN, three times
        for (int i = 1; i <= 3; i++) begin
            LOCK = 1'b0;
            step(2);
            check("loss_cnten_hold", {7'd0, CNT_EN}, 8'd1);
            step(1);
            check("loss_cnten_drop", {7'd0, CNT_EN}, 8'd0);
            check("loss_state", {5'd0, STATE}, S_HOLD);
            check("loss_cnt", LOSS_CNT, 8'(i));
            LOCK = 1'b1;
            wait_state(S_RUN, 40, "loss_recover");
        end
        check("loss_total", LOSS_CNT, 8'd3);

        // Restart from RUN, then a one-cycle lock glitch during SETTLE
        RESTART = 1'b1;
        step(1);
        RESTART = 1'b0;
        check("restart_state", {5'd0, STATE}, S_HOLD);
        check("restart_loss", LOSS_CNT, 8'd3);
        wait_state(S_SETTLE, 20, "glitch_settle");
        step(4);
        LOCK = 1'b0;
        step(1);
        LOCK = 1'b1;
        step(1);
        check("glitch_still_settle", {5'd0, STATE}, S_SETTLE);
        step(1);
        check("glitch_hold", {5'd0, STATE}, S_HOLD);
        check("glitch_retries", {6'd0, dut.retry_q}, 8'd1);
        wait_state(S_RUN, 40, "glitch_recover");
        check("glitch_ready", {7'd0, READY}, 8'd1);

        // RESTART coinciding with a lock drop seen in RUN
        LOCK = 1'b0;
        step(2);
        RESTART = 1'b1;
        step(1);
        RESTART = 1'b0;
        check("rl_state", {5'd0, STATE}, S_HOLD);
        check("rl_loss", LOSS_CNT, 8'd3);
        check("rl_retries", {6'd0, dut.retry_q}, 8'd0);

        // Timeout: three attempts of 4 HOLD + 32 WAIT_LOCK cycles
        step(4);
        check("to1_wait", {5'd0, STATE}, S_WAIT);
        step(31);
        check("to1_last", {5'd0, STATE}, S_WAIT);
        step(1);
        check("to1_hold", {5'd0, STATE}, S_HOLD);
        check("to1_retries", {6'd0, dut.retry_q}, 8'd1);
        step(35);
        check("to2_last", {5'd0, STATE}, S_WAIT);
        step(1);
        check("to2_hold", {5'd0, STATE}, S_HOLD);
        check("to2_retries", {6'd0, dut.retry_q}, 8'd2);
        step(35);
        check("to3_last", {5'd0, STATE}, S_WAIT);
        step(1);
        check("fault_state", {5'd0, STATE}, S_FAULT);
        check("fault_flag", {7'd0, FAULT}, 8'd1);
        check("fault_pllrb", {7'd0, PLL_RESETB}, 8'd0);
        check("fault_cntclr", {7'd0, CNT_CLR}, 8'd1);
        step(100);
        check("fault_persist", {5'd0, STATE}, S_FAULT);
        check("fault_persist_flag", {7'd0, FAULT}, 8'd1);

        // RESTART out of FAULT
        RESTART = 1'b1;
        step(1);
        RESTART = 1'b0;
        check("fr_state", {5'd0, STATE}, S_HOLD);
        check("fr_retries", {6'd0, dut.retry_q}, 8'd0);
        check("fr_fault", {7'd0, FAULT}, 8'd0);
        check("fr_loss", LOSS_CNT, 8'd3);
        LOCK = 1'b1;
        wait_state(S_RUN, 40, "fr_recover");

        // Asynchronous reset while in RUN
        #2 RESETB = 1'b0;
        #1;
        check("areset_cnten", {7'd0, CNT_EN}, 8'd0);
        check("areset_state", {5'd0, STATE}, S_HOLD);
        check("areset_loss", LOSS_CNT, 8'd0);
        check("areset_pllrb", {7'd0, PLL_RESETB}, 8'd0);
        step(2);
        RESETB = 1'b1;
        step(1);
        check("arel_hold", {5'd0, STATE}, S_HOLD);
        wait_state(S_RUN, 40, "arel_recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
